uart_rx: RTL and testbench

UART receiver that deserialises the asynchronous rx_i line of cpu_top into bytes. It buffers received bytes in a small FIFO and presents them to the CPU peripheral bus through a valid/ready interface. It is the input-side counterpart of the UART transmitter that drives tx_o. It also flags framing errors and overruns.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/sync_fifo.sv | 63 ++++++
 rtl/uart_rx.sv | 143 ++++++++++++++
 tb/tb_uart_rx.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM encoding, data width and a
// constant-evaluable ceiling log2 used to size counters and pointers.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StStart    = 3'd1,
    StData     = 3'd2,
    StStop     = 3'd3,
    StWaitHigh = 3'd4
  } rx_state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    int unsigned v;
    res = 0;
    if (value > 1) begin
      for (v = value - 1; v > 0; v = v >> 1) begin
        res = res + 1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an extra pointer bit to tell full from empty.
// A push while full is taken only when a pop happens in the same cycle.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AddrW = clog2(Depth);

  logic [AddrW:0]   wr_ptr_q, wr_ptr_d;
  logic [AddrW:0]   rd_ptr_q, rd_ptr_d;
  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic             push_ok, pop_ok;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign data_o  = mem_q[rd_ptr_q[AddrW-1:0]];

  // Pop on empty is dropped, so push+pop on empty just pushes.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q[AddrW-1:0]] = data_i;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 deserialiser sampling mid-bit, feeding a small FIFO
// with valid/ready output, plus framing-error and overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100000000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int unsigned CPB  = CLK_FREQ_HZ / BAUD;
  localparam int unsigned HALF = CPB / 2;
  localparam int unsigned CntW = clog2(CPB);
  localparam int unsigned BitW = clog2(DATA_BITS);

  localparam logic [CntW-1:0] HalfM1 = CntW'(HALF - 1);
  localparam logic [CntW-1:0] CpbM1  = CntW'(CPB - 1);
  localparam logic [BitW-1:0] LastBit = BitW'(DATA_BITS - 1);

  rx_state_e            state_q, state_d;
  logic                 sync1_q, rx_s_q;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 push, pop, full, empty;

  assign pop         = !empty && ready_i;
  assign valid_o     = !empty;
  assign busy_o      = (state_q != StIdle);
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    push        = 1'b0;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!rx_s_q) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        if (cnt_q == HalfM1) begin
          cnt_d     = '0;
          bit_cnt_d = '0;
          state_d   = rx_s_q ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        if (cnt_q == CpbM1) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
          if (bit_cnt_q == LastBit) begin
            state_d = StStop;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (cnt_q == CpbM1) begin
          cnt_d = '0;
          if (rx_s_q) begin
            push      = 1'b1;
            overrun_d = full && !pop;
            state_d   = StIdle;
          end else begin
            frame_err_d = 1'b1;
            state_d     = StWaitHigh;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWaitHigh: begin
        // A held-low line (break) must return high before a new frame.
        if (rx_s_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sync1_q     <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= rx_i;
      rx_s_q      <= sync1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  sync_fifo #(
    .Width (DATA_BITS),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_i),
    .push_i  (push),
    .data_i  (shift_q),
    .pop_i   (pop),
    .data_o  (data_o),
    .full_o  (full),
    .empty_o (empty)
  );

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with CPB=10, HALF=5: frames, glitch, framing
// error, overrun, pop-on-full at the stop sample, and mid-frame reset.
module tb_uart_rx;

  localparam int unsigned Cpb = 10;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx    = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid, fe, ov, busy;

  int n_checks = 0;
  int n_fails  = 0;
  int fe_cnt   = 0;
  int ov_cnt   = 0;
  int both_cnt = 0;
  int long_cnt = 0;
  int snap;
  logic fe_prev = 1'b0;
  logic ov_prev = 1'b0;

  uart_rx #(
    .CLK_FREQ_HZ (1000000),
    .BAUD        (100000),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .rx_i        (rx),
    .data_o      (data),
    .valid_o     (valid),
    .ready_i     (ready),
    .frame_err_o (fe),
    .overrun_o   (ov),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  // Pulse monitor: counts error pulses, coincidences and over-long pulses.
  always @(negedge clk) begin
    if (fe) fe_cnt <= fe_cnt + 1;
    if (ov) ov_cnt <= ov_cnt + 1;
    if (fe && ov) both_cnt <= both_cnt + 1;
    if ((fe && fe_prev) || (ov && ov_prev)) long_cnt <= long_cnt + 1;
    fe_prev <= fe;
    ov_prev <= ov;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      $error("%s differs", tag);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    rx = b;
    repeat (Cpb) @(posedge clk);
  endtask

  // With pop_at_stop, ready is high exactly on the stop-sample edge (A+97).
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic pop_at_stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    if (!pop_at_stop) begin
      send_bit(stop);
    end else begin
      @(negedge clk);
      rx = stop;
      repeat (7) @(posedge clk);
      #1 ready = 1'b1;
      @(posedge clk);
      #1 ready = 1'b0;
      repeat (2) @(posedge clk);
    end
  endtask

  task automatic pop_expect(input logic [7:0] exp, input string tag);
    @(negedge clk);
    check({tag, "_valid"}, 32'(valid), 32'd1);
    check({tag, "_data"}, 32'(data), 32'(exp));
    ready = 1'b1;
    @(posedge clk);
    #1 ready = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fe", 32'(fe), 32'd0);
    check("rst_ov", 32'(ov), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // 1: single frame, then one-cycle pop
    send_frame(8'h55, 1'b1, 1'b0);
    @(negedge clk);
    check("t1_valid", 32'(valid), 32'd1);
    check("t1_data", 32'(data), 32'h55);
    check("t1_busy", 32'(busy), 32'd0);
    ready = 1'b1;
    @(posedge clk);
    #1 ready = 1'b0;
    check("t1_popped", 32'(valid), 32'd0);

    // 2: 3-cycle low glitch is a false start
    snap = fe_cnt;
    @(negedge clk);
    rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("t2_busy_start", 32'(busy), 32'd1);
    rx = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("t2_busy_idle", 32'(busy), 32'd0);
    check("t2_valid", 32'(valid), 32'd0);
    check("t2_fe", 32'(fe_cnt - snap), 32'd0);

    // 3: framing error, then a good frame after the line idles high
    snap = fe_cnt;
    send_frame(8'hA3, 1'b0, 1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    @(negedge clk);
    check("t3_fe_pulses", 32'(fe_cnt - snap), 32'd1);
    check("t3_valid", 32'(valid), 32'd0);
    check("t3_busy", 32'(busy), 32'd0);
    send_frame(8'h3C, 1'b1, 1'b0);
    pop_expect(8'h3C, "t3_pop");
    @(negedge clk);
    check("t3_empty", 32'(valid), 32'd0);
    check("t3_fe_once", 32'(fe_cnt - snap), 32'd1);

    // 4: five frames into a 4-deep FIFO
    snap = ov_cnt;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0);
    @(negedge clk);
    check("t4_ov_pulses", 32'(ov_cnt - snap), 32'd1);
    for (int i = 1; i <= 4; i++) pop_expect(8'(i), "t4_drain");
    @(negedge clk);
    check("t4_empty", 32'(valid), 32'd0);

    // 5: pop coincident with the 5th stop sample avoids overrun
    snap = ov_cnt;
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 1'b0);
    send_frame(8'h05, 1'b1, 1'b1);
    @(negedge clk);
    check("t5_ov_pulses", 32'(ov_cnt - snap), 32'd0);
    for (int i = 2; i <= 5; i++) pop_expect(8'(i), "t5_drain");
    @(negedge clk);
    check("t5_empty", 32'(valid), 32'd0);

    // 6: reset during bit 4 with a byte already queued
    send_frame(8'h99, 1'b1, 1'b0);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'(8'hAB >> i));
    @(negedge clk);
    rx = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(valid), 32'd0);
    check("t6_rst_data", 32'(data), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_fe", 32'(fe), 32'd0);
    check("t6_rst_ov", 32'(ov), 32'd0);
    rx = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    send_frame(8'h7E, 1'b1, 1'b0);
    pop_expect(8'h7E, "t6_pop");
    @(negedge clk);
    check("t6_empty", 32'(valid), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);

    // Pulse shape over the whole run
    check("pulse_overlap", 32'(both_cnt), 32'd0);
    check("pulse_length", 32'(long_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
